// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte FIFO between the uart core and the SoC bus decoder.
//   A small capture FSM drains each valid byte from the uart and acknowledges
//   it with a one-cycle uart_rd_o pulse. Bytes are queued in arrival order and
//   popped by CPU data-register reads. data_o is first-word fall-through.
//
//   Optional feature macro: UART_RX_FIFO_STATS_EN
//     defined   -> drop_count_o counts dropped bytes (saturating at 16'hFFFF)
//     undefined -> drop_count_o tied to 16'd0; the port list is unchanged
//
// Ports
//   clk             in   system clock
//   reset_i         in   synchronous active-high reset
//   uart_valid_i    in   uart has a received byte
//   uart_data_i     in   received byte
//   uart_rd_o       out  one-cycle acknowledge to the uart (registered)
//   pop_i           in   CPU read strobe on the data register
//   data_o          out  head byte, 0 when empty
//   empty_o         out  FIFO holds no entries (registered)
//   full_o          out  FIFO holds DEPTH entries (registered)
//   level_o         out  entry count 0..DEPTH (registered)
//   overflow_o      out  sticky: a byte was dropped while full
//   clr_overflow_i  in   clears overflow_o and drop_count_o
//   drop_count_o    out  dropped-byte counter
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          uart_valid_i,
    input  logic [7:0]    uart_data_i,
    output logic          uart_rd_o,
    input  logic          pop_i,
    output logic [7:0]    data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [LW-1:0] level_o,
    output logic          overflow_o,
    input  logic          clr_overflow_i,
    output logic [15:0]   drop_count_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } cap_state_t;

    cap_state_t    state_r;
    cap_state_t    state_next_s;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_next_s;
    logic          empty_r;
    logic          full_r;
    logic          uart_rd_r;
    logic          overflow_r;
    logic [7:0]    mem_r [DEPTH];
    logic          capture_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    // Capture/pop decisions and next-state logic. A pop in the same cycle
    // as a capture on a full FIFO frees a slot, so the byte is accepted.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        pop_s        = pop_i && !empty_r;
        push_s       = 1'b0;
        drop_s       = 1'b0;
        level_next_s = level_r;

        case (state_r)
            IDLE: begin
                if (uart_valid_i) begin
                    capture_s    = 1'b1;
                    state_next_s = ACK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACK: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                // Hold off until the uart drops valid so one byte is not captured twice.
                if (!uart_valid_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        if (capture_s) begin
            push_s = !full_r || pop_s;
            drop_s = full_r && !pop_s;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end

        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Control state: FSM, pointers, level, registered flags and ack.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_r    <= IDLE;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            uart_rd_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            level_r   <= level_next_s;
            empty_r   <= (level_next_s == {LW{1'b0}});
            full_r    <= (level_next_s == LW'(DEPTH));
            uart_rd_r <= (state_next_s == ACK);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            // A new drop wins over a same-cycle clear.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (push_s && !reset_i) begin
            mem_r[wr_ptr_r] <= uart_data_i;
        end
    end

`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] drop_cnt_r;

    // Saturating dropped-byte counter; a same-cycle drop beats the clear.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s) begin
            if (clr_overflow_i) begin
                drop_cnt_r <= 16'd1;
            end else if (drop_cnt_r == 16'hFFFF) begin
                drop_cnt_r <= drop_cnt_r;
            end else begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end else if (clr_overflow_i) begin
            drop_cnt_r <= 16'd0;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_count_o = drop_cnt_r;
`else
    assign drop_count_o = 16'd0;
`endif

    assign uart_rd_o  = uart_rd_r;
    assign data_o     = empty_r ? 8'h00 : mem_r[rd_ptr_r];
    assign empty_o    = empty_r;
    assign full_o     = full_r;
    assign level_o    = level_r;
    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios followed by a
// randomized phase. A queue-based reference model tracks the expected FIFO
// contents and flags; a negedge monitor compares every DUT output.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset_i;
    logic          uart_valid_i;
    logic [7:0]    uart_data_i;
    logic          uart_rd_o;
    logic          pop_i;
    logic [7:0]    data_o;
    logic          empty_o;
    logic          full_o;
    logic [LW-1:0] level_o;
    logic          overflow_o;
    logic          clr_overflow_i;
    logic [15:0]   drop_count_o;

    int vec_cnt;
    int miscmp_cnt;
    bit chk_en;
    bit rnd_done;
    int pop_div;

    // Reference model state
    logic [7:0]  q[$];
    bit          m_ack;
    bit          m_busy;
    bit          m_ovf;
    logic [15:0] m_cnt;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .uart_valid_i   (uart_valid_i),
        .uart_data_i    (uart_data_i),
        .uart_rd_o      (uart_rd_o),
        .pop_i          (pop_i),
        .data_o         (data_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .level_o        (level_o),
        .overflow_o     (overflow_o),
        .clr_overflow_i (clr_overflow_i),
        .drop_count_o   (drop_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a byte is taken whenever the uart side is ready
    // and valid is high; it is queued if room exists after any pop, else
    // dropped. The uart side is not ready again until the ack cycle has
    // passed and valid has been seen low.
    always @(posedge clk) begin
        bit cap;
        bit drop;
        if (reset_i) begin
            q.delete();
            m_ack  = 1'b0;
            m_busy = 1'b0;
            m_ovf  = 1'b0;
            m_cnt  = 16'd0;
        end else begin
            cap  = !m_busy && uart_valid_i;
            drop = 1'b0;
            if (pop_i && q.size() > 0) void'(q.pop_front());
            if (cap) begin
                if (q.size() < DEPTH) q.push_back(uart_data_i);
                else drop = 1'b1;
            end
            if (cap) m_busy = 1'b1;
            else if (!m_ack && !uart_valid_i) m_busy = 1'b0;
            m_ack = cap;
            if (drop) m_ovf = 1'b1;
            else if (clr_overflow_i) m_ovf = 1'b0;
`ifdef UART_RX_FIFO_STATS_EN
            if (drop) m_cnt = clr_overflow_i ? 16'd1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1);
            else if (clr_overflow_i) m_cnt = 16'd0;
`endif
        end
    end

    // Monitor: compare all outputs against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("level", 32'(level_o), 32'(q.size()));
            chk("empty", 32'(empty_o), 32'(q.size() == 0));
            chk("full", 32'(full_o), 32'(q.size() == DEPTH));
            chk("level_bound", 32'(level_o <= DEPTH), 32'd1);
            chk("overflow", 32'(overflow_o), 32'(m_ovf));
            chk("uart_rd", 32'(uart_rd_o), 32'(m_ack));
            chk("drop_count", 32'(drop_count_o), 32'(m_cnt));
            if (q.size() > 0) begin
                if (pop_i) chk("pop_data", 32'(data_o), 32'(q[0]));
                else chk("head_data", 32'(data_o), 32'(q[0]));
            end else begin
                chk("empty_data", 32'(data_o), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Offer one byte like a uart: hold valid until acked, then release.
    task automatic send_byte(input logic [7:0] b, input int hold);
        bit got;
        uart_valid_i = 1'b1;
        uart_data_i  = b;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            if (uart_rd_o) got = 1'b1;
        end
        if (!got) begin
            vec_cnt++;
            miscmp_cnt++;
            $display("FAIL ack_timeout: got 0 expected 1 at %0t", $time);
        end
        repeat (hold) step();
        uart_valid_i = 1'b0;
        step();
        step();
    endtask

    task automatic pop_one();
        pop_i = 1'b1;
        step();
        pop_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) pop_one();
        chk("drain_empty", 32'(empty_o), 32'd1);
    endtask

    initial begin
        vec_cnt        = 0;
        miscmp_cnt     = 0;
        chk_en         = 1'b0;
        rnd_done       = 1'b0;
        pop_div        = 8;
        reset_i        = 1'b1;
        uart_valid_i   = 1'b0;
        uart_data_i    = 8'h00;
        pop_i          = 1'b0;
        clr_overflow_i = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        reset_i = 1'b0;
        step();

        // 1: valid held 3 cycles -> one capture, one ack pulse
        uart_valid_i = 1'b1;
        uart_data_i  = 8'hA5;
        repeat (3) step();
        uart_valid_i = 1'b0;
        step();
        step();
        chk("t1_one_entry", 32'(level_o), 32'd1);
        chk("t1_data", 32'(data_o), 32'hA5);
        pop_one();

        // 2: fill with 01..10, then drain in order
        for (int i = 1; i <= DEPTH; i++) send_byte(8'(i), 0);
        chk("t2_full", 32'(full_o), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("t2_order", 32'(data_o), 32'(i));
            pop_one();
        end
        chk("t2_empty", 32'(empty_o), 32'd1);

        // 3: full FIFO drops 8'hEE
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 8'hED)), 0);
        send_byte(8'hEE, 1);
        chk("t3_overflow", 32'(overflow_o), 32'd1);
        chk("t3_level", 32'(level_o), 32'(DEPTH));

        // 4: full FIFO, pop in the same cycle as the capture of 8'h77
        uart_valid_i = 1'b1;
        uart_data_i  = 8'h77;
        pop_i        = 1'b1;
        step();
        pop_i = 1'b0;
        step();
        uart_valid_i = 1'b0;
        step();
        step();
        chk("t4_level", 32'(level_o), 32'(DEPTH));
        for (int i = 0; i < DEPTH - 1; i++) pop_one();
        chk("t4_last", 32'(data_o), 32'h77);
        pop_one();

        // 5: pop when empty, then clear overflow
        pop_one();
        chk("t5_data", 32'(data_o), 32'd0);
        chk("t5_level", 32'(level_o), 32'd0);
        clr_overflow_i = 1'b1;
        step();
        clr_overflow_i = 1'b0;
        chk("t5_clr", 32'(overflow_o), 32'd0);
        chk("t5_cnt", 32'(drop_count_o), 32'd0);

        // 6: reset while in ACK with 5 bytes queued
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
        uart_valid_i = 1'b1;
        uart_data_i  = 8'h33;
        step();
        reset_i      = 1'b1;
        uart_valid_i = 1'b0;
        step();
        reset_i = 1'b0;
        chk("t6_level", 32'(level_o), 32'd0);
        chk("t6_rd", 32'(uart_rd_o), 32'd0);
        step();

        // 7: randomized traffic across the pointer wrap, slow then fast drain
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if (i == 30) pop_div = 2;
                    send_byte(8'($urandom), int'($urandom_range(0, 2)));
                    repeat ($urandom_range(0, 2)) step();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    pop_i          = ($urandom_range(0, pop_div - 1) == 0);
                    clr_overflow_i = ($urandom_range(0, 40) == 0);
                    step();
                end
                pop_i          = 1'b0;
                clr_overflow_i = 1'b0;
            end
        join
        drain();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
